// File: rtl/spike_fifo_reader.sv
// Pops spike address words from an upstream FIFO into a single-entry output register,
// drops NULL markers, counts delivered events and runs an end-of-timestep drain.
module spike_fifo_reader #(
   parameter int DATA_WIDTH = 14,
   parameter int ROW_BITS   = 7,
   parameter logic [DATA_WIDTH-1:0] NULL_ADDR = '1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_enable,
   input  logic                           i_drain,
   input  logic                           i_fifo_empty,
   input  logic [DATA_WIDTH-1:0]          i_fifo_rd_data,
   output logic                           o_fifo_rd_en,
   output logic                           o_spk_valid,
   output logic [ROW_BITS-1:0]            o_spk_row,
   output logic [DATA_WIDTH-ROW_BITS-1:0] o_spk_col,
   input  logic                           i_spk_ready,
   output logic                           o_busy,
   output logic                           o_drain_done,
   output logic [15:0]                    o_spk_count,
   output logic [15:0]                    o_ts_count
);
   localparam int COL_BITS = DATA_WIDTH - ROW_BITS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nxt;
   logic   load, hs, is_null;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Drain request outranks enable changes; once draining, only completion leaves.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_drain) state_nxt = DRAIN;
                  else if (i_enable) state_nxt = RUN;
         RUN:     if (i_drain) state_nxt = DRAIN;
                  else if (!i_enable) state_nxt = IDLE;
         DRAIN:   if (o_drain_done) state_nxt = i_enable ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gating with rst_n keeps the FIFO from losing a word while reset is held.
   always_comb begin
      hs           = o_spk_valid & i_spk_ready;
      load         = rst_n & (state != IDLE) & ~i_fifo_empty & (~o_spk_valid | i_spk_ready);
      o_fifo_rd_en = load;
      o_drain_done = rst_n & (state == DRAIN) & i_fifo_empty & ~o_spk_valid;
      o_busy       = (state != IDLE) | o_spk_valid;
   end

   assign is_null = (i_fifo_rd_data == NULL_ADDR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_spk_valid <= 1'b0;
         o_spk_row   <= '0;
         o_spk_col   <= '0;
      end else if (load && !is_null) begin
         o_spk_valid <= 1'b1;
         o_spk_row   <= i_fifo_rd_data[DATA_WIDTH-1 -: ROW_BITS];
         o_spk_col   <= i_fifo_rd_data[COL_BITS-1:0];
      end else if (hs) begin
         o_spk_valid <= 1'b0;
      end
   end

   // Completion requires an empty output register, so no handshake is lost at the roll-over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_spk_count <= '0;
         o_ts_count  <= '0;
      end else if (o_drain_done) begin
         o_ts_count  <= o_spk_count;
         o_spk_count <= '0;
      end else if (hs && o_spk_count != 16'hFFFF) begin
         o_spk_count <= o_spk_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_spike_fifo_reader.sv
// Randomized and directed bench for spike_fifo_reader against a queue-based reference model.
module tb_spike_fifo_reader;
   logic        clk = 1'b0;
   logic        rst_n, i_enable, i_drain, i_fifo_empty, i_spk_ready;
   logic [13:0] i_fifo_rd_data;
   logic        o_fifo_rd_en, o_spk_valid, o_busy, o_drain_done;
   logic [6:0]  o_spk_row, o_spk_col;
   logic [15:0] o_spk_count, o_ts_count;

   spike_fifo_reader dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_drain(i_drain),
      .i_fifo_empty(i_fifo_empty), .i_fifo_rd_data(i_fifo_rd_data),
      .o_fifo_rd_en(o_fifo_rd_en), .o_spk_valid(o_spk_valid),
      .o_spk_row(o_spk_row), .o_spk_col(o_spk_col), .i_spk_ready(i_spk_ready),
      .o_busy(o_busy), .o_drain_done(o_drain_done),
      .o_spk_count(o_spk_count), .o_ts_count(o_ts_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int pop_cnt = 0, done_cnt = 0;
   bit chk_en = 0;
   logic [13:0] fq[$];
   logic [13:0] dlv[$];

   // reference model: mode 0=idle 1=run 2=drain
   int m_mode, m_cnt, m_ts, m_word;
   bit m_held;
   bit s_load, s_hs, s_done, s_rd_dut;
   int s_word;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic refresh();
      i_fifo_empty   = (fq.size() == 0);
      i_fifo_rd_data = (fq.size() == 0) ? 14'h0 : fq[0];
   endtask

   task automatic push(input logic [13:0] w);
      fq.push_back(w);
      refresh();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         refresh();
      end
   endtask

   // compare at negedge, advance model at posedge
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         bit emp, exp_rd, exp_done;
         emp      = (fq.size() == 0);
         exp_rd   = rst_n && m_mode != 0 && !emp && (!m_held || i_spk_ready);
         exp_done = rst_n && m_mode == 2 && emp && !m_held;
         chk("valid", int'(o_spk_valid), int'(m_held));
         chk("rd_en", int'(o_fifo_rd_en), int'(exp_rd));
         chk("done", int'(o_drain_done), int'(exp_done));
         chk("busy", int'(o_busy), int'(m_mode != 0 || m_held));
         chk("row", int'(o_spk_row), m_word / 128);
         chk("col", int'(o_spk_col), m_word % 128);
         chk("spk_count", int'(o_spk_count), m_cnt);
         chk("ts_count", int'(o_ts_count), m_ts);
         if (o_spk_valid && i_spk_ready) dlv.push_back({o_spk_row, o_spk_col});
         if (o_drain_done) done_cnt++;
         s_load   = exp_rd;
         s_hs     = m_held && i_spk_ready;
         s_done   = exp_done;
         s_rd_dut = o_fifo_rd_en;
         s_word   = emp ? 0 : int'(fq[0]);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_mode = 0; m_held = 0; m_word = 0; m_cnt = 0; m_ts = 0;
      end else if (chk_en) begin
         if (s_load && s_word != 14'h3FFF) begin
            m_held = 1; m_word = s_word;
         end else if (s_hs) m_held = 0;
         if (s_done) begin
            m_ts = m_cnt; m_cnt = 0;
         end else if (s_hs && m_cnt < 65535) m_cnt++;
         case (m_mode)
            0: if (i_drain) m_mode = 2; else if (i_enable) m_mode = 1;
            1: if (i_drain) m_mode = 2; else if (!i_enable) m_mode = 0;
            default: if (s_done) m_mode = i_enable ? 1 : 0;
         endcase
      end
      if (chk_en && s_rd_dut) begin
         if (fq.size() == 0) chk("pop_on_empty", 1, 0);
         else begin
            void'(fq.pop_front());
            pop_cnt++;
         end
      end
   end

   initial begin
      int d0, p0, n0;
      rst_n = 0; i_enable = 0; i_drain = 0; i_spk_ready = 0;
      refresh();
      tick(2);
      chk_en = 1;
      chk("rst_count", int'(o_spk_count), 0);
      chk("rst_valid", int'(o_spk_valid), 0);

      // single event, 1-cycle latency
      rst_n = 1; i_enable = 1; i_spk_ready = 1;
      tick(1);
      push(14'h0A05);
      @(negedge clk); chk("t1_rd_en", int'(o_fifo_rd_en), 1);
      tick(1);
      @(negedge clk);
      chk("t1_valid", int'(o_spk_valid), 1);
      chk("t1_row", int'(o_spk_row), 'h14);
      chk("t1_col", int'(o_spk_col), 'h05);
      tick(1);
      chk("t1_count", int'(o_spk_count), 1);

      // backpressure: one pop while stalled, then back-to-back
      i_spk_ready = 0;
      push(14'h0101); push(14'h0102); push(14'h0103); push(14'h0104);
      p0 = pop_cnt; d0 = dlv.size();
      tick(3);
      chk("stall_pops", pop_cnt - p0, 1);
      chk("stall_row", int'(o_spk_row), 2);
      chk("stall_col", int'(o_spk_col), 1);
      i_spk_ready = 1;
      tick(5);
      chk("burst_events", dlv.size() - d0, 4);
      chk("burst_count", int'(o_spk_count), 5);

      // NULL marker dropped
      d0 = dlv.size();
      push(14'h0001); push(14'h3FFF); push(14'h0002);
      tick(6);
      chk("null_events", dlv.size() - d0, 2);
      chk("null_first", int'(dlv[d0]), 'h0001);
      chk("null_second", int'(dlv[d0+1]), 'h0002);
      chk("null_count", int'(o_spk_count), 7);

      // drain while disabled
      i_enable = 0;
      tick(2);
      push(14'h0011); push(14'h0022); push(14'h0033);
      n0 = done_cnt;
      tick(2);
      chk("idle_no_pop", fq.size(), 3);
      i_drain = 1; tick(1); i_drain = 0;
      tick(8);
      chk("drain_pulses", done_cnt - n0, 1);
      chk("drain_ts", int'(o_ts_count), 10);
      chk("drain_count", int'(o_spk_count), 0);
      chk("drain_busy", int'(o_busy), 0);

      // drain with nothing pending
      i_enable = 1;
      push(14'h0100); push(14'h0200);
      tick(4);
      i_enable = 0;
      tick(2);
      i_drain = 1; tick(1); i_drain = 0;
      @(negedge clk); chk("empty_drain_done", int'(o_drain_done), 1);
      tick(1);
      chk("empty_drain_ts", int'(o_ts_count), 2);

      // reset mid-drain with held event
      i_spk_ready = 0; i_enable = 1;
      push(14'h0123); push(14'h0124);
      tick(3);
      i_drain = 1; tick(1); i_drain = 0;
      tick(1);
      chk("pre_rst_valid", int'(o_spk_valid), 1);
      n0 = done_cnt;
      rst_n = 0; tick(1); rst_n = 1;
      @(negedge clk);
      chk("rst_drop_valid", int'(o_spk_valid), 0);
      chk("rst_drop_count", int'(o_spk_count), 0);
      chk("rst_drop_ts", int'(o_ts_count), 0);
      chk("rst_no_done", done_cnt - n0, 0);
      tick(1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         i_enable    = ($urandom_range(0, 9) < 7);
         i_drain     = ($urandom_range(0, 39) == 0);
         i_spk_ready = ($urandom_range(0, 3) != 0);
         rst_n       = ($urandom_range(0, 499) != 0);
         if (fq.size() < 8 && $urandom_range(0, 2) != 0)
            push(($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 16383)));
         tick(1);
      end

      // final flush
      rst_n = 1; i_enable = 0; i_spk_ready = 1; i_drain = 1;
      tick(1); i_drain = 0;
      tick(40);
      chk("final_busy", int'(o_busy), 0);
      chk("final_fifo", fq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spike_fifo_reader.md
SPIKE_FIFO_READER -- requirements
Module: spike_fifo_reader

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-low, rst_n.
REQ-002 Parameter DATA_WIDTH, default 14: width of one spike address word.
REQ-003 Parameter ROW_BITS, default 7: number of upper address bits forming the row field; the column field is DATA_WIDTH-ROW_BITS bits.
REQ-004 Parameter NULL_ADDR, default all-ones: marker word that is popped and discarded.
REQ-005 Ports SHALL be:
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  i_enable  in  1  permit normal dispatch
  i_drain  in  1  end-of-timestep drain request, sampled when high for one or more cycles
  i_fifo_empty  in  1  upstream FIFO empty
  i_fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid combinationally whenever i_fifo_empty=0
  o_fifo_rd_en  out  1  pop request; the head word is consumed on the edge where this is high
  o_spk_valid  out  1  output event valid
  o_spk_row  out  ROW_BITS  row field of event
  o_spk_col  out  DATA_WIDTH-ROW_BITS  column field of event
  i_spk_ready  in  1  downstream accepts event
  o_busy  out  1  state is not IDLE or output register holds an event
  o_drain_done  out  1  one-cycle pulse at drain completion
  o_spk_count  out  16  events delivered in the current timestep
  o_ts_count  out  16  event count latched at the last drain completion

Function
REQ-006 The block SHALL hold exactly one event in an output register; o_spk_valid reflects register occupancy.
REQ-007 Load condition = pop-permitted state AND i_fifo_empty=0 AND (o_spk_valid=0 OR i_spk_ready=1); o_fifo_rd_en SHALL equal this condition combinationally and SHALL never be high while i_fifo_empty=1.
REQ-008 On a load edge, i_fifo_rd_data SHALL be captured and split into row = upper ROW_BITS, col = lower bits; o_spk_valid is high the next cycle (1-cycle latency from FIFO head to output).
REQ-009 A popped word equal to NULL_ADDR SHALL NOT be loaded into the output register: o_spk_valid clears if its current event handshakes that cycle, otherwise it holds, and the word is not counted.
REQ-010 With i_fifo_empty=0 and i_spk_ready=1 held, throughput SHALL be one event per cycle.
REQ-011 While o_spk_valid=1 and i_spk_ready=0, row, col and valid SHALL hold stable.
REQ-012 A handshake is o_spk_valid=1 AND i_spk_ready=1; each increments o_spk_count, saturating at 16'hFFFF.
REQ-013 FSM states: IDLE, RUN, DRAIN. Pops are permitted in RUN and DRAIN only.
REQ-014 IDLE->RUN when i_enable=1; RUN->IDLE when i_enable=0; an event already in the output register is still delivered in IDLE.
REQ-015 IDLE or RUN -> DRAIN when i_drain=1 (priority over enable transitions); i_drain is ignored while in DRAIN.
REQ-016 In DRAIN, popping continues regardless of i_enable; words written upstream during drain extend the drain.
REQ-017 Drain completes in the first DRAIN cycle with i_fifo_empty=1 AND o_spk_valid=0: o_drain_done pulses that cycle, o_ts_count <= o_spk_count, o_spk_count <= 0, next state RUN if i_enable=1 else IDLE.
REQ-018 No handshake can coincide with completion (REQ-017 requires o_spk_valid=0), so no count is lost.

Reset
REQ-019 While rst_n=0 at a clk edge: state IDLE, output register empty, o_spk_valid=0, o_spk_row=0, o_spk_col=0, o_drain_done=0, o_spk_count=0, o_ts_count=0; o_fifo_rd_en=0 and o_busy=0 follow combinationally.
REQ-020 Reset asserted mid-drain or with a held event SHALL discard that event and abort the drain with no o_drain_done pulse.

Verification
REQ-021 Enable=1, FIFO holds 14'h0A05, ready=1 -> rd_en high one cycle; next cycle valid=1, row=7'h14, col=7'h05; count=1.
REQ-022 FIFO holds 4 words, ready low for 3 cycles then high -> one pop only while stalled, outputs stable, then 4 events in consecutive cycles, count=4.
REQ-023 FIFO words 14'h0001, 14'h3FFF, 14'h0002, ready=1 -> exactly two events (0x0001, 0x0002), count=2.
REQ-024 Enable=0, FIFO holds 3 words, pulse i_drain -> all 3 delivered, o_drain_done one pulse after last handshake, o_ts_count=3, o_spk_count=0, state IDLE.
REQ-025 Drain with FIFO empty and no held event -> o_drain_done on the cycle after the i_drain edge, o_ts_count equals prior count.
REQ-026 rst_n low mid-drain with valid=1 -> next cycle valid=0, counts 0, no o_drain_done pulse.
